// File: rtl/sliding_window_buffer_pkg.sv
// sliding_window_buffer_pkg: width helpers, wrapped pointer add and stride clamp
package sliding_window_buffer_pkg;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  // compare-and-subtract wrap; valid because ptr < depth and inc <= depth
  function automatic int unsigned mod_add(input int unsigned ptr, input int unsigned inc, input int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    return sum >= depth ? sum - depth : sum;
  endfunction
  function automatic int unsigned clamp_stride(input int unsigned stride, input int unsigned par_read);
    return stride > par_read ? par_read : stride;
  endfunction
endpackage

// File: rtl/sliding_window_buffer_ctrl.sv
// sliding_window_buffer_ctrl: occupancy count, ready/valid, acceptance, flush priority, sticky flags
// ports: clk, rst (async), flush, write_en, read_en, stride in; ready, valid, wacc, racc, step, count, overflow, underflow out
module sliding_window_buffer_ctrl
  import sliding_window_buffer_pkg::*;
#(
  parameter int PAR_WRITE = 1,
  parameter int PAR_READ = 4,
  parameter int DEPTH = 16,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int SW = $clog2(PAR_READ + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [SW-1:0]    stride,
  output logic             ready,
  output logic             valid,
  output logic             wacc,
  output logic             racc,
  output logic [SW-1:0]    step,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);
  assign ready = DEPTH - int'(count) >= PAR_WRITE;
  assign valid = int'(count) >= PAR_READ;
  assign step = SW'(clamp_stride(int'(stride), PAR_READ));
  assign wacc = write_en & ready & ~flush;
  assign racc = read_en & valid & ~flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= CNT_W'(int'(count) + (wacc ? PAR_WRITE : 0) - (racc ? int'(step) : 0));
      overflow <= overflow | (write_en & ~ready);
      underflow <= underflow | (read_en & ~valid);
    end
  end
endmodule

// File: rtl/sliding_window_buffer.sv
// sliding_window_buffer: circular buffer with PAR_WRITE-word writes and a PAR_READ-word strided window
// ports: clk, rst (async), flush, write_en, din, read_en, stride in; ready, dout, valid, count, overflow, underflow out
module sliding_window_buffer
  import sliding_window_buffer_pkg::*;
#(
  parameter int PAR_WRITE = 1,
  parameter int PAR_READ = 4,
  parameter int DEPTH = 16,
  parameter int BITS = 16,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int SW = $clog2(PAR_READ + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     write_en,
  input  logic [BITS*PAR_WRITE-1:0] din,
  output logic                     ready,
  input  logic                     read_en,
  input  logic [SW-1:0]            stride,
  output logic [BITS*PAR_READ-1:0] dout,
  output logic                     valid,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow,
  output logic                     underflow
);
  logic [BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic wacc, racc;
  logic [SW-1:0] step;
  sliding_window_buffer_ctrl #(.PAR_WRITE(PAR_WRITE), .PAR_READ(PAR_READ), .DEPTH(DEPTH)) u_ctrl (
    .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .read_en(read_en), .stride(stride),
    .ready(ready), .valid(valid), .wacc(wacc), .racc(racc), .step(step), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wacc) wptr <= PTR_W'(mod_add(32'(wptr), PAR_WRITE, DEPTH));
      if (racc) rptr <= PTR_W'(mod_add(32'(rptr), 32'(step), DEPTH));
    end
  end
  // flush keeps memory contents; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wacc) for (int i = 0; i < PAR_WRITE; i++) mem[PTR_W'(mod_add(32'(wptr), i, DEPTH))] <= din[i*BITS +: BITS];
  end
  for (genvar j = 0; j < PAR_READ; j++) begin : g_win
    assign dout[j*BITS +: BITS] = mem[PTR_W'(mod_add(32'(rptr), j, DEPTH))];
  end
endmodule

// File: tb/tb_sliding_window_buffer.sv
// tb_sliding_window_buffer: random and directed checks of two buffer configurations against a queue model
module tb_sliding_window_buffer;
  logic clk = 0, rst = 1;
  logic fl [2], we [2], re [2], rdy [2], vld [2], ovf [2], unf [2];
  logic [2:0] stride [2];
  logic [15:0] din_a;
  logic [31:0] din_b;
  logic [63:0] dout_a, dout_b;
  logic [4:0] cnt_a;
  logic [3:0] cnt_b;
  logic [15:0] qa [$], qb [$];
  bit ovf_m [2], unf_m [2];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  sliding_window_buffer #(.PAR_WRITE(1), .PAR_READ(4), .DEPTH(16), .BITS(16)) dut_a (
    .clk(clk), .rst(rst), .flush(fl[0]), .write_en(we[0]), .din(din_a), .ready(rdy[0]),
    .read_en(re[0]), .stride(stride[0]), .dout(dout_a), .valid(vld[0]), .count(cnt_a),
    .overflow(ovf[0]), .underflow(unf[0])
  );
  sliding_window_buffer #(.PAR_WRITE(2), .PAR_READ(4), .DEPTH(10), .BITS(16)) dut_b (
    .clk(clk), .rst(rst), .flush(fl[1]), .write_en(we[1]), .din(din_b), .ready(rdy[1]),
    .read_en(re[1]), .stride(stride[1]), .dout(dout_b), .valid(vld[1]), .count(cnt_b),
    .overflow(ovf[1]), .underflow(unf[1])
  );
  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask
  task automatic chk_state(input int k, input int n, input bit rdy_e, input bit vld_e, input logic [63:0] win, input bit win_chk);
    chk("count", k, k ? 64'(cnt_b) : 64'(cnt_a), 64'(n));
    chk("ready", k, 64'(rdy[k]), 64'(rdy_e));
    chk("valid", k, 64'(vld[k]), 64'(vld_e));
    chk("overflow", k, 64'(ovf[k]), 64'(ovf_m[k]));
    chk("underflow", k, 64'(unf[k]), 64'(unf_m[k]));
    if (win_chk) chk("window", k, k ? dout_b : dout_a, win);
  endtask
  // one clock: drive at posedge+1, check pre-edge state at negedge, then apply the model at the edge
  task automatic cyc(input int k, input bit w, input logic [31:0] d, input bit r, input int st, input bit f);
    logic [15:0] q [$];
    int pw, dep, n, s;
    bit rdy_e, vld_e;
    logic [63:0] win;
    if (k == 0) q = qa; else q = qb;
    pw = k ? 2 : 1;
    dep = k ? 10 : 16;
    we[k] = w; re[k] = r; fl[k] = f; stride[k] = 3'(st);
    if (k == 0) din_a = d[15:0]; else din_b = d;
    @(negedge clk);
    n = q.size();
    rdy_e = dep - n >= pw;
    vld_e = n >= 4;
    win = vld_e ? {q[3], q[2], q[1], q[0]} : '0;
    chk_state(k, n, rdy_e, vld_e, win, vld_e);
    @(posedge clk);
    #1;
    we[k] = 0; re[k] = 0; fl[k] = 0;
    if (f) begin
      q.delete();
      ovf_m[k] = 0;
      unf_m[k] = 0;
    end else begin
      s = st > 4 ? 4 : st;
      if (w && !rdy_e) ovf_m[k] = 1;
      if (r && !vld_e) unf_m[k] = 1;
      if (r && vld_e) repeat (s) void'(q.pop_front());
      if (w && rdy_e) for (int i = 0; i < pw; i++) q.push_back(d[i*16 +: 16]);
    end
    if (k == 0) qa = q; else qb = q;
  endtask
  initial begin
    int nxt;
    bit w, r;
    for (int k = 0; k < 2; k++) begin
      fl[k] = 0; we[k] = 0; re[k] = 0; stride[k] = 0;
    end
    din_a = 0; din_b = 0;
    #12;
    chk_state(0, 0, 1, 0, 64'd0, 1);
    chk_state(1, 0, 1, 0, 64'd0, 1);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 100 + i, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0);
    cyc(0, 1, 107, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    qa.delete(); qb.delete();
    for (int k = 0; k < 2; k++) begin
      ovf_m[k] = 0; unf_m[k] = 0;
    end
    chk_state(0, 0, 1, 0, 64'd0, 1);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) cyc(0, 1, i, 0, 0, 0);
    for (int i = 5; i <= 7; i++) cyc(0, 1, i, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 10; i <= 25; i++) cyc(0, 1, i, 0, 0, 0);
    cyc(0, 1, 99, 0, 0, 0);
    cyc(0, 1, 98, 1, 4, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 7, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 1, 77, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    nxt = 0;
    for (int c = 0; c < 300 && (nxt < 30 || qb.size() >= 4); c++) begin
      w = nxt < 30 && 10 - qb.size() >= 2 && $urandom_range(3) != 0;
      r = 1'($urandom_range(1));
      cyc(1, w, {16'(nxt + 1), 16'(nxt)}, r, 4, 0);
      if (w) nxt += 2;
    end
    cyc(1, 1, 32'h0001_0002, 1, 3, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 200; c++)
      cyc(0, 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), $urandom_range(7), $urandom_range(15) == 0);
    cyc(0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
